// File: rtl/clk_run_ctrl_pkg.sv
// clk_run_pkg: shared types and defaults for the clock run/stop controller.
//   clk_run_state_t : controller FSM states (encoding visible on state_o)
//   DEFAULT_*       : default settle / stop-delay lengths in controller cycles
//   clk_run_cnt_w   : timer width large enough for either phase length
package clk_run_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    STARTING = 2'd1,
    RUNNING  = 2'd2,
    DRAINING = 2'd3
  } clk_run_state_t;

  localparam int unsigned DEFAULT_SETTLE_CYCLES = 4;
  localparam int unsigned DEFAULT_STOP_DELAY    = 8;

  function automatic int unsigned clk_run_cnt_w(input int unsigned a,
                                                input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_run_ctrl_if.sv
// clk_run_ctrl_if: request/grant bundle between clock consumers and the
// run/stop controller.
//   req       consumers -> ctrl  per-requester level run request
//   force_run consumers -> ctrl  keep clock running, never acknowledged
//   ack       ctrl -> consumers  per-requester grant (clock stable)
//   run_en    ctrl -> source     clock source run state
//   busy      ctrl -> anyone     controller not STOPPED
//   state_o   ctrl -> anyone     FSM state (debug)
interface clk_run_ctrl_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req;
  logic               force_run;
  logic [NUM_REQ-1:0] ack;
  logic               run_en;
  logic               busy;
  logic [1:0]         state_o;

  modport master (
    output req, force_run,
    input  ack, run_en, busy, state_o
  );

  modport slave (
    input  req, force_run,
    output ack, run_en, busy, state_o
  );
endinterface

// File: rtl/clk_run_timer.sv
// clk_run_timer: loadable down-counter shared by the settle and drain phases.
//   clk, rst  clock, asynchronous active-high reset (clears count)
//   load      load load_val this cycle (has priority over dec)
//   load_val  value to load
//   dec       decrement; counter holds at zero
//   zero      count is zero (from the register)
module clk_run_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/clk_run_ctrl.sv
// clk_run_ctrl: arbitrated run/stop controller for a shared clock source.
// Collects requests, holds run_en through a settle period before granting
// acks, and drops run_en only after STOP_DELAY idle cycles.
//   clk, rst   controller clock, asynchronous active-high reset
//   bus        clk_run_ctrl_if slave: req, force_run in; ack, run_en,
//              busy, state_o out (all registered)
// Optional (macro CLK_RUN_STATS_EN):
//   start_cnt  saturating count of STOPPED->STARTING transitions
//   run_cycles saturating count of cycles with run_en high
module clk_run_ctrl
  import clk_run_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int unsigned STOP_DELAY    = DEFAULT_STOP_DELAY
) (
  input  logic           clk,
  input  logic           rst,
  clk_run_ctrl_if.slave  bus
`ifdef CLK_RUN_STATS_EN
  ,
  output logic [31:0]    start_cnt,
  output logic [31:0]    run_cycles
`endif
);
  localparam int unsigned CNT_W = clk_run_cnt_w(SETTLE_CYCLES, STOP_DELAY);

  clk_run_state_t     state_q, state_d;
  logic               run_en_q, run_en_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic               any_req;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;

  assign any_req = (|bus.req) | bus.force_run;

  clk_run_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    run_en_d = run_en_q;
    ack_d    = ack_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      STOPPED: begin
        ack_d = '0;
        if (any_req) begin
          state_d  = STARTING;
          run_en_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      STARTING: begin
        // Settle always completes; whoever still requests at the end is granted.
        if (tmr_zero) begin
          state_d = RUNNING;
          ack_d   = bus.req;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RUNNING: begin
        ack_d = bus.req;
        if (!any_req) begin
          state_d  = DRAINING;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(STOP_DELAY - 1);
        end
      end
      DRAINING: begin
        ack_d = '0;
        // A request on the timeout edge wins: clock never stops.
        if (any_req) begin
          state_d = RUNNING;
          ack_d   = bus.req;
        end else if (tmr_zero) begin
          state_d  = STOPPED;
          run_en_d = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = STOPPED;
    endcase
    busy_d = (state_d != STOPPED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STOPPED;
      run_en_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_en_q <= run_en_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.run_en  = run_en_q;
  assign bus.busy    = busy_q;
  assign bus.state_o = state_q;

`ifdef CLK_RUN_STATS_EN
  logic [31:0] start_cnt_q, start_cnt_d;
  logic [31:0] run_cycles_q, run_cycles_d;

  always_comb begin
    start_cnt_d  = start_cnt_q;
    run_cycles_d = run_cycles_q;
    if ((state_q == STOPPED) && (state_d == STARTING) && (start_cnt_q != '1))
      start_cnt_d = start_cnt_q + 32'd1;
    if (run_en_q && (run_cycles_q != '1))
      run_cycles_d = run_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt_q  <= '0;
      run_cycles_q <= '0;
    end else begin
      start_cnt_q  <= start_cnt_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign start_cnt  = start_cnt_q;
  assign run_cycles = run_cycles_q;
`endif
endmodule

// File: tb/tb_clk_run_ctrl.sv
// tb_clk_run_ctrl: directed test-plan scenarios plus randomized request
// traffic, checked every cycle against an event-count model of the
// controller. Build with CLK_RUN_STATS_EN to also check the counters.
module tb_clk_run_ctrl;
  localparam int unsigned NR     = 4;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned STOP   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_run_ctrl_if #(.NUM_REQ(NR)) bus ();

`ifdef CLK_RUN_STATS_EN
  logic [31:0] start_cnt, run_cycles;
`endif

  clk_run_ctrl #(
    .NUM_REQ       (NR),
    .SETTLE_CYCLES (SETTLE),
    .STOP_DELAY    (STOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CLK_RUN_STATS_EN
    ,
    .start_cnt  (start_cnt),
    .run_cycles (run_cycles)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: clock on/off, edges since start, consecutive idle edges once stable.
  bit          m_on, m_stable, m_any;
  int unsigned m_age, m_idle;
  logic [NR-1:0] m_ack;
  longint      m_starts, m_runc;

  function automatic logic [1:0] m_state();
    if (!m_on)        return 2'd0;
    if (!m_stable)    return 2'd1;
    if (m_idle == 0)  return 2'd2;
    return 2'd3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = 0; m_stable = 0; m_age = 0; m_idle = 0; m_ack = '0;
      m_starts = 0; m_runc = 0;
    end else begin
      m_any = (|bus.req) || bus.force_run;
      if (m_on) m_runc++;
      if (!m_on) begin
        m_ack = '0;
        if (m_any) begin
          m_on = 1; m_age = 0; m_stable = 0; m_starts++;
        end
      end else if (!m_stable) begin
        m_age++;
        if (m_age == SETTLE) begin
          m_stable = 1; m_idle = 0; m_ack = bus.req;
        end
      end else if (m_any) begin
        m_idle = 0; m_ack = bus.req;
      end else begin
        m_idle++; m_ack = '0;
        if (m_idle > STOP) begin
          m_on = 0; m_stable = 0;
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cyc_ack",    32'(bus.ack),     32'(m_ack));
      check("cyc_run_en", 32'(bus.run_en),  32'(m_on));
      check("cyc_busy",   32'(bus.busy),    32'(m_on));
      check("cyc_state",  32'(bus.state_o), 32'(m_state()));
`ifdef CLK_RUN_STATS_EN
      check("cyc_start_cnt",  start_cnt,
            (m_starts > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_starts[31:0]);
      check("cyc_run_cycles", run_cycles,
            (m_runc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_runc[31:0]);
`endif
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string name, input logic [NR-1:0] ack,
                         input logic run_en, input logic [1:0] st);
    check({name, "_ack"},    32'(bus.ack),     32'(ack));
    check({name, "_run_en"}, 32'(bus.run_en),  32'(run_en));
    check({name, "_state"},  32'(bus.state_o), 32'(st));
    check({name, "_busy"},   32'(bus.busy),    32'(st != 2'd0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0;
    bus.force_run = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_out("in_reset", 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    step(1);
    chk_out("post_reset", 4'b0000, 1'b0, 2'd0);

    // Basic start
    bus.req = 4'b0001;
    step(1); chk_out("start_E0", 4'b0000, 1'b1, 2'd1);
    step(3); chk_out("start_E3", 4'b0000, 1'b1, 2'd1);
    step(1); chk_out("start_E4", 4'b0001, 1'b1, 2'd2);
    check("model_state_E4", 32'(m_state()), 32'd2);

    // Idle stop
    bus.req = '0;
    step(1); chk_out("stop_D0", 4'b0000, 1'b1, 2'd3);
    step(7); chk_out("stop_D7", 4'b0000, 1'b1, 2'd3);
    step(1); chk_out("stop_D8", 4'b0000, 1'b0, 2'd0);
    check("model_on_D8", 32'(m_on), 32'd0);

    // Re-request while draining
    bus.req = 4'b0001;
    step(5); chk_out("rereq_run", 4'b0001, 1'b1, 2'd2);
    bus.req = '0;
    step(3); chk_out("rereq_D2", 4'b0000, 1'b1, 2'd3);
    bus.req = 4'b0100;
    step(1); chk_out("rereq_D3", 4'b0100, 1'b1, 2'd2);

    // Timeout race
    bus.req = '0;
    step(8); chk_out("race_D7", 4'b0000, 1'b1, 2'd3);
    bus.req = 4'b0010;
    step(1); chk_out("race_D8", 4'b0010, 1'b1, 2'd2);

    // Reset mid-STARTING
    bus.req = '0;
    step(10); chk_out("idle_again", 4'b0000, 1'b0, 2'd0);
    bus.req = 4'b0001;
    step(2); chk_out("mid_start_E1", 4'b0000, 1'b1, 2'd1);
    step(1);
    #1 rst = 1'b1;
    #1 chk_out("async_rst", 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(1); chk_out("restart_E0", 4'b0000, 1'b1, 2'd1);
    step(3); chk_out("restart_E3", 4'b0000, 1'b1, 2'd1);
    step(1); chk_out("restart_E4", 4'b0001, 1'b1, 2'd2);

    // force_run alone, from a fresh reset
    bus.req = '0;
    step(10);
    rst = 1'b1;
    #2 rst = 1'b0;
    bus.force_run = 1'b1;
    step(1);  chk_out("force_E0", 4'b0000, 1'b1, 2'd1);
    step(19); chk_out("force_E19", 4'b0000, 1'b1, 2'd2);
    bus.force_run = 1'b0;
    step(8);  chk_out("force_E27", 4'b0000, 1'b1, 2'd3);
    step(1);  chk_out("force_E28", 4'b0000, 1'b0, 2'd0);
`ifdef CLK_RUN_STATS_EN
    check("stats_start_cnt", start_cnt, 32'd1);
    check("stats_run_cycles", run_cycles, 32'd28);
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      int unsigned hold;
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 35) bus.req = '0;
      else        bus.req = NR'($urandom);
      bus.force_run = ($urandom_range(0, 99) < 15);
      hold = $urandom_range(1, 14);
      if ($urandom_range(0, 99) < 4) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
      step(hold);
    end

    bus.req = '0;
    bus.force_run = 1'b0;
    step(12);
    chk_out("final_idle", 4'b0000, 1'b0, 2'd0);
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
